// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter sharing one up-counter
// between two requesters that each ask for a timed interval.
module counter_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             tick,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] l_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             busy_q;
    logic             last_q;

    logic             pick0_d;
    logic             any_req_d;
    logic [WIDTH-1:0] win_len_d;
    logic             own_req_d;
    logic             at_end_d;

    // Arbitration and end-of-interval decode from registered state.
    always_comb begin
        pick0_d   = req0 & (~req1 | last_q);
        any_req_d = req0 | req1;
        win_len_d = pick0_d ? len0 : len1;
        own_req_d = gnt_q[1] ? req1 : req0;
        at_end_d  = (q_q == l_q - WIDTH'(1));
    end

    // Controller FSM; all outputs are registered here.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            l_q     <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        l_q    <= win_len_d;
                        q_q    <= '0;
                        gnt_q  <= pick0_d ? 2'b01 : 2'b10;
                        busy_q <= 1'b1;
                        if (win_len_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= pick0_d ? 2'b01 : 2'b10;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!own_req_d) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        last_q  <= gnt_q[1];
                    end else if (tick) begin
                        if (at_end_d) begin
                            q_q     <= l_q;
                            state_q <= S_DONE;
                            done_q  <= gnt_q;
                        end else begin
                            q_q <= q_q + WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                    last_q  <= gnt_q[1];
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign busy  = busy_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed and random stimulus against a
// transaction-level model of the shared-counter scheduler.
module tb_counter_scheduler;

    logic        clock = 1'b0;
    logic        clear;
    logic        tick;
    logic        req0;
    logic        req1;
    logic [15:0] len0;
    logic [15:0] len1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        busy;
    logic [15:0] Q;

    int errors = 0;
    int checks = 0;

    // Model: current owner (-1 none), count, length, done flag, last owner.
    int          m_own;
    int          m_last;
    bit          m_done;
    int unsigned m_q;
    int unsigned m_len;

    counter_scheduler #(.WIDTH(16)) dut (
        .clock (clock),
        .clear (clear),
        .tick  (tick),
        .req0  (req0),
        .req1  (req1),
        .len0  (len0),
        .len1  (len1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .busy  (busy),
        .Q     (Q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 1;
        m_done = 1'b0;
        m_q    = 0;
        m_len  = 0;
    endtask

    task automatic model_edge();
        bit r [2];
        int unsigned ln [2];
        int w;
        r[0]  = req0;
        r[1]  = req1;
        ln[0] = len0;
        ln[1] = len1;
        if (!clear) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
            m_last = m_own;
            m_own  = -1;
        end else if (m_own >= 0) begin
            if (!r[m_own]) begin
                m_last = m_own;
                m_own  = -1;
            end else if (tick) begin
                m_q = (m_q + 1) % 65536;
                if (m_q == m_len) m_done = 1'b1;
            end
        end else if (r[0] || r[1]) begin
            if (r[0] && r[1]) w = 1 - m_last;
            else w = r[0] ? 0 : 1;
            m_own  = w;
            m_len  = ln[w];
            m_q    = 0;
            m_done = (m_len == 0);
        end
    endtask

    task automatic check_all();
        chk("gnt0", gnt0, m_own == 0);
        chk("gnt1", gnt1, m_own == 1);
        chk("done0", done0, m_done && m_own == 0);
        chk("done1", done1, m_done && m_own == 1);
        chk("busy", busy, m_own >= 0);
        chk("Q", Q, m_q);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int n;
        int grants;
        int order [4];
        bit pg;

        clear = 1'b0;
        tick  = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        len0  = '0;
        len1  = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clock);
        clear = 1'b1;

        // reset in the middle of an interval
        req0 = 1'b1;
        len0 = 16'd10;
        tick = 1'b1;
        n = 0;
        while (Q != 16'd4 && n < 50) begin
            step();
            n++;
        end
        chk("midrun_q4", Q, 32'd4);
        #2 clear = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("midrun_gnt0", gnt0, 32'd0);
        chk("midrun_busy", busy, 32'd0);
        chk("midrun_q", Q, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        req1  = 1'b1;
        len0  = 16'd1;
        len1  = 16'd1;
        step();
        chk("tie_first_gnt0", gnt0, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();

        // single interval of 5 ticks
        req0 = 1'b1;
        len0 = 16'd5;
        tick = 1'b1;
        step();
        chk("single_gnt", gnt0, 32'd1);
        chk("single_q0", Q, 32'd0);
        n = 0;
        while (!done0 && n < 20) begin
            step();
            n++;
        end
        chk("single_done", done0, 32'd1);
        chk("single_done_q", Q, 32'd5);
        chk("single_lat", n, 32'd5);
        req0 = 1'b0;
        step();
        chk("single_gnt_drop", gnt0, 32'd0);

        // sparse tick, every 4th cycle
        req1 = 1'b1;
        len1 = 16'd3;
        n = 0;
        while (!done1 && n < 40) begin
            tick = (n % 4 == 3);
            step();
            n++;
        end
        chk("sparse_done", done1, 32'd1);
        chk("sparse_q", Q, 32'd3);
        chk("sparse_window", (n >= 9 && n <= 15), 32'd1);
        req1 = 1'b0;
        tick = 1'b0;
        step();

        // round-robin tie
        req0 = 1'b1;
        req1 = 1'b1;
        len0 = 16'd2;
        len1 = 16'd3;
        tick = 1'b1;
        grants = 0;
        pg = 1'b0;
        n = 0;
        while (grants < 4 && n < 60) begin
            step();
            n++;
            if ((gnt0 || gnt1) && !pg) begin
                order[grants] = gnt1 ? 1 : 0;
                grants++;
            end
            pg = gnt0 || gnt1;
        end
        chk("rr_grants", grants, 32'd4);
        chk("rr_order0", order[0], 32'd0);
        chk("rr_order1", order[1], 32'd1);
        chk("rr_order2", order[2], 32'd0);
        chk("rr_order3", order[3], 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();

        // zero length
        req0 = 1'b1;
        len0 = 16'd0;
        step();
        chk("zero_gnt", gnt0, 32'd1);
        chk("zero_done", done0, 32'd1);
        chk("zero_q", Q, 32'd0);
        req0 = 1'b0;
        step();
        chk("zero_gnt_drop", gnt0, 32'd0);

        // maximum length
        req1 = 1'b1;
        len1 = 16'hFFFF;
        tick = 1'b1;
        step();
        n = 0;
        while (!done1 && n < 70000) begin
            step();
            n++;
        end
        chk("max_done", done1, 32'd1);
        chk("max_q", Q, 32'hFFFF);
        chk("max_ticks", n, 32'd65535);
        req1 = 1'b0;
        step();
        chk("max_hold_q", Q, 32'hFFFF);
        chk("max_gnt_drop", gnt1, 32'd0);

        // abort with a pending competitor
        req1 = 1'b1;
        len1 = 16'd8;
        step();
        chk("abort_gnt1", gnt1, 32'd1);
        req0 = 1'b1;
        n = 0;
        while (Q != 16'd2 && n < 10) begin
            step();
            n++;
        end
        chk("abort_q2", Q, 32'd2);
        req1 = 1'b0;
        step();
        chk("abort_busy", busy, 32'd0);
        chk("abort_hold_q", Q, 32'd2);
        chk("abort_no_done", done1, 32'd0);
        req1 = 1'b1;
        step();
        chk("abort_next_gnt0", gnt0, 32'd1);
        chk("abort_next_gnt1", gnt1, 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (m_own == 0) req0 = ($urandom_range(0, 15) != 0);
            else req0 = ($urandom_range(0, 2) != 0);
            if (m_own == 1) req1 = ($urandom_range(0, 15) != 0);
            else req1 = ($urandom_range(0, 2) != 0);
            len0 = 16'($urandom_range(0, 5));
            len1 = 16'($urandom_range(0, 5));
            tick = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
